// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter.
//   PAR_NONE / PAR_ODD / PAR_EVEN : parity-mode selectors for the PARITY parameter
//   tx_state_e                     : transmitter FSM state encoding
//   clks_per_bit()                 : rounded clock cycles per serial bit
package uart_pkg;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   typedef enum logic [2:0] {
      StIdle,
      StStartBit,
      StData,
      StParityBit,
      StStop
   } tx_state_e;

   // Rounded to the nearest integer so odd clock/baud ratios err by at most half a cycle.
   function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                input int unsigned baud);
      return (clk_freq + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter.
//   CLK  : clock
//   RST  : synchronous active-high reset (count returns to 0)
//   CLR  : restart the count at 0 on the next edge (frame accept)
//   TICK : high during the last cycle of each CLKS_PER_BIT-cycle period
module uart_baud_gen #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic CLK,
   input  logic RST,
   input  logic CLR,
   output logic TICK
);

   localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (CLR || (cnt_q == CNT_LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign TICK = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: one frame per accepted START.
// Frame = start bit (0), DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits (1). Each bit lasts CLKS_PER_BIT clocks.
//   CLK     : clock
//   RST     : synchronous active-high reset; aborts any frame in progress
//   START   : send request, only sampled while idle
//   DATA    : word to send, captured on the accept edge
//   BUSY    : high while a frame is in progress
//   DONE    : one-cycle pulse in the first idle cycle after the last stop bit
//   TX_LINE : serial output, idle high
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50000000,
   parameter int unsigned BAUD      = 9600,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = PAR_NONE,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic [DATA_BITS-1:0] DATA,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 TX_LINE
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam bit          HAS_PARITY   = (PARITY != PAR_NONE);
   localparam logic        PAR_INV      = (PARITY == PAR_ODD);
   localparam logic [3:0]  DATA_LAST    = 4'(DATA_BITS - 1);
   localparam logic [3:0]  STOP_LAST    = 4'(STOP_BITS - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_cfg: CLKS_PER_BIT must be at least 2");
   end
   if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
      $error("uart_tx_cfg: DATA_BITS must be in 5..9");
   end
   if (PARITY > PAR_EVEN) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
   end
   if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
   end

   tx_state_e            state_q;
   tx_state_e            state_d;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] shift_d;
   logic [3:0]           idx_q;
   logic [3:0]           idx_d;
   logic                 par_q;
   logic                 par_d;
   logic                 tx_q;
   logic                 tx_d;
   logic                 busy_q;
   logic                 busy_d;
   logic                 done_q;
   logic                 done_d;
   logic                 accept;
   logic                 tick;

   assign accept = (state_q == StIdle) && START;

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_gen (
      .CLK  (CLK),
      .RST  (RST),
      .CLR  (accept),
      .TICK (tick)
   );

   // State and datapath registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         shift_q <= '0;
         idx_q   <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         par_q   <= par_d;
      end
   end

   // Next-state logic. idx_q counts data bits in StData and stop bits in StStop.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      par_d   = par_q;
      unique case (state_q)
         StIdle: begin
            if (START) begin
               state_d = StStartBit;
               shift_d = DATA;
               idx_d   = '0;
               // Parity is fixed at accept time since the shifter is consumed bit by bit.
               par_d   = (^DATA) ^ PAR_INV;
            end
         end
         StStartBit: begin
            if (tick) begin
               state_d = StData;
            end
         end
         StData: begin
            if (tick) begin
               if (idx_q == DATA_LAST) begin
                  idx_d   = '0;
                  state_d = HAS_PARITY ? StParityBit : StStop;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  shift_d = shift_q >> 1;
               end
            end
         end
         StParityBit: begin
            if (tick) begin
               state_d = StStop;
            end
         end
         StStop: begin
            if (tick) begin
               if (idx_q == STOP_LAST) begin
                  idx_d   = '0;
                  state_d = StIdle;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line up
   // with the state they belong to.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         StStartBit:  tx_d = 1'b0;
         StData:      tx_d = shift_d[0];
         StParityBit: tx_d = par_d;
         default:     tx_d = 1'b1;
      endcase
      busy_d = (state_d != StIdle);
      done_d = (state_q == StStop) && (state_d == StIdle);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         tx_q   <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         tx_q   <= tx_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign TX_LINE = tx_q;
   assign BUSY    = busy_q;
   assign DONE    = done_q;

endmodule
